split_gen: RTL and testbench
============================

SPLIT_GEN -- requirements
Module: split_gen

Interface
REQ-001 Parameter SHIFT, default 9: constraint shift amount, legal range 1..17.
REQ-002 Parameter MAX_RETRY, default 15: number of rejected candidates that ends a request with failure, legal range 1..255.
REQ-003 Parameter SEED, default 18'h00001: LFSR value after reset.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request one constrained value; sampled only in IDLE or on an out_valid/out_ready accept edge.
REQ-007 seed_load  in  1  load seed into the LFSR; honoured only in IDLE.
REQ-008 seed  in  18  seed value.
REQ-009 out_valid  out  1  out_data holds an accepted candidate.
REQ-010 out_ready  in  1  consumer accepts out_data.
REQ-011 out_data  out  18  generated value.
REQ-012 busy  out  1  high in GEN or VALID.
REQ-013 fail  out  1  one-cycle pulse when MAX_RETRY rejects occur.
REQ-014 retry_count  out  8  rejects for the current or most recent request.

Function
REQ-015 The block SHALL produce 18-bit values v for which the constraint check |(~(v >> SHIFT)) holds on the bits that survive the shift: v[17:SHIFT] SHALL NOT be all ones.
REQ-016 The LFSR SHALL be a left-shifting Fibonacci register: next = {lfsr[16:0], lfsr[17]^lfsr[10]}.
REQ-017 Any zero seed, from seed or SEED, SHALL be replaced by 18'h00001.
REQ-018 States: IDLE, GEN, VALID.
  - IDLE to GEN on start; retry_count clears to 0 on this transition.
REQ-019 In GEN, the LFSR SHALL step every cycle, and the candidate SHALL be the stepped value.
  - Pass: latch the candidate into out_data and go to VALID.
  - Reject: increment retry_count.
REQ-020 When the reject just counted makes retry_count equal MAX_RETRY, the block SHALL pulse fail for one cycle and return to IDLE without asserting out_valid.
REQ-021 Latency: start at edge N with a passing first candidate gives out_valid high after edge N+1; each reject adds exactly one cycle.
REQ-022 In VALID, out_valid SHALL stay high and out_data stable until out_ready is high at an edge.
  - The LFSR SHALL NOT step while in VALID.
REQ-023 On an accept edge, the block SHALL go to GEN if start is high on that edge, otherwise to IDLE.
REQ-024 start SHALL be ignored in GEN, and seed_load SHALL be ignored outside IDLE.
REQ-025 If seed_load and start are both high in IDLE, the seed SHALL load and the first candidate SHALL be derived from the loaded seed.
REQ-026 retry_count SHALL saturate at 255.

Reset
REQ-027 On rst_n low, the block SHALL immediately and asynchronously:
  - go to IDLE;
  - load SEED (or 1 if SEED is zero) into the LFSR;
  - clear out_valid, out_data, fail and retry_count to 0, and busy to 0.
REQ-028 A reset during GEN or VALID SHALL abandon the request, and out_valid SHALL NOT assert after reset release without a new start.

Configuration
REQ-029 With SPLIT_GEN_STATS_EN defined, the block SHALL add two 16-bit wrapping outputs, both reset to 0:
  - stat_accepted: counts out_valid/out_ready accepts;
  - stat_rejected: counts rejected candidates.
REQ-030 Without SPLIT_GEN_STATS_EN, these ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-031 A shared package split_gen_pkg SHALL hold:
  - the state enum;
  - the LFSR width (18) and tap positions (17, 10);
  - a constraint-check function that takes value and SHIFT.
REQ-032 The design SHALL contain one sub-module, split_gen_lfsr, providing step, load and zero-seed substitution; the FSM and handshake SHALL reside in split_gen.

Verification
REQ-033 Load seed 18'h00001, start -> out_valid after 1 cycle, out_data = 18'h00002, retry_count = 0.
REQ-034 SHIFT=9, MAX_RETRY=15, seed 18'h3FFFF, start -> 9 rejects, then out_data = 18'h3FC00, retry_count = 9, out_valid on cycle 10.
REQ-035 Same as REQ-034 but MAX_RETRY=9 -> fail pulses one cycle after the 9th reject, out_valid never asserts, state IDLE.
REQ-036 Hold out_ready low 5 cycles in VALID -> out_data stable and LFSR frozen; then out_ready and start high together -> next candidate generated with no IDLE cycle.
REQ-037 Load seed 18'h00000, start -> behaves as seed 1 (out_data = 18'h00002); assert rst_n low mid-GEN -> all outputs 0 immediately, no out_valid after release.
REQ-038 With SPLIT_GEN_STATS_EN, the REQ-034 sequence plus one accept -> stat_rejected = 9, stat_accepted = 1.

Source files
------------

// File: rtl/split_gen_pkg.sv
// Shared definitions for split_gen: FSM states, LFSR geometry and the
// value-constraint check used by the generator.
package split_gen_pkg;

    localparam int LFSR_W = 18;
    localparam int TAP_HI = 17;
    localparam int TAP_LO = 10;

    localparam logic [LFSR_W-1:0] LFSR_ONE  = 18'h00001;
    localparam logic [LFSR_W-1:0] LFSR_ONES = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    // A candidate passes unless every bit that survives the shift is one.
    function automatic logic constraint_ok(input logic [LFSR_W-1:0] v, input int shift);
        return (v >> shift) != (LFSR_ONES >> shift);
    endfunction

    // An all-zero LFSR would lock up, so zero seeds become 1.
    function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] s);
        return (s == '0) ? LFSR_ONE : s;
    endfunction

endpackage

// File: rtl/split_gen_if.sv
// Request/response bundle of split_gen. The master side drives requests and
// the ready; the slave side (the generator) returns data and status.
interface split_gen_if;
    import split_gen_pkg::*;

    logic              start;
    logic              seed_load;
    logic [LFSR_W-1:0] seed;
    logic              out_valid;
    logic              out_ready;
    logic [LFSR_W-1:0] out_data;
    logic              busy;
    logic              fail;
    logic [7:0]        retry_count;

    modport master (
        output start, seed_load, seed, out_ready,
        input  out_valid, out_data, busy, fail, retry_count
    );

    modport slave (
        input  start, seed_load, seed, out_ready,
        output out_valid, out_data, busy, fail, retry_count
    );

endinterface

// File: rtl/split_gen_lfsr.sv
// 18-bit left-shifting Fibonacci LFSR with seed load and zero-seed
// substitution. Exposes the stepped value so the caller can test the
// candidate in the same cycle the register advances.
module split_gen_lfsr
    import split_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 18'h00001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] next_value
);

    localparam logic [LFSR_W-1:0] RESET_VAL = fix_seed(SEED);

    logic [LFSR_W-1:0] lfsr;

    assign next_value = {lfsr[LFSR_W-2:0], lfsr[TAP_HI] ^ lfsr[TAP_LO]};

    // Load has priority over step; the register holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= RESET_VAL;
        end else if (load) begin
            lfsr <= fix_seed(seed);
        end else if (step) begin
            lfsr <= next_value;
        end
    end

endmodule

// File: rtl/split_gen.sv
// Constrained random value generator. Each start request steps the LFSR
// once per cycle until a candidate passes the constraint check, then holds
// it on a valid/ready handshake; MAX_RETRY rejects end the request with a
// one-cycle fail pulse.
// Optional feature: define SPLIT_GEN_STATS_EN to add stat_accepted and
// stat_rejected wrapping counters.
module split_gen
    import split_gen_pkg::*;
#(
    parameter int                SHIFT     = 9,
    parameter int                MAX_RETRY = 15,
    parameter logic [LFSR_W-1:0] SEED      = 18'h00001
) (
    input  logic        clk,
    input  logic        rst_n,
    split_gen_if.slave  bus
`ifdef SPLIT_GEN_STATS_EN
    ,
    output logic [15:0] stat_accepted,
    output logic [15:0] stat_rejected
`endif
);

    localparam logic [7:0] MAX_R = 8'(MAX_RETRY);

    state_t            state;
    logic              out_valid;
    logic [LFSR_W-1:0] out_data;
    logic              busy;
    logic              fail;
    logic [7:0]        retry_count;

    logic [LFSR_W-1:0] cand;
    logic              cand_pass;
    logic              lfsr_step;
    logic              lfsr_load;
    logic [8:0]        retry_inc;
    logic [7:0]        retry_sat;
    logic              accept;

    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_data;
    assign bus.busy        = busy;
    assign bus.fail        = fail;
    assign bus.retry_count = retry_count;

    // The LFSR only moves while generating, and seeds only load while idle.
    assign lfsr_step = (state == ST_GEN);
    assign lfsr_load = (state == ST_IDLE) && bus.seed_load;

    split_gen_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (lfsr_step),
        .load       (lfsr_load),
        .seed       (bus.seed),
        .next_value (cand)
    );

    assign cand_pass = constraint_ok(cand, SHIFT);
    assign retry_inc = {1'b0, retry_count} + 9'd1;
    assign retry_sat = retry_inc[8] ? 8'hFF : retry_inc[7:0];
    assign accept    = (state == ST_VALID) && bus.out_ready;

    // Request FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            out_valid   <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            fail        <= 1'b0;
            retry_count <= '0;
        end else begin
            fail <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state       <= ST_GEN;
                        busy        <= 1'b1;
                        retry_count <= '0;
                    end
                end
                ST_GEN: begin
                    if (cand_pass) begin
                        state     <= ST_VALID;
                        out_valid <= 1'b1;
                        out_data  <= cand;
                    end else begin
                        retry_count <= retry_sat;
                        if (retry_sat == MAX_R) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            fail  <= 1'b1;
                        end
                    end
                end
                ST_VALID: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        if (bus.start) begin
                            // Back-to-back request: straight into GEN.
                            state       <= ST_GEN;
                            retry_count <= '0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPLIT_GEN_STATS_EN
    // Wrapping event counters for accepts and rejected candidates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_accepted <= '0;
            stat_rejected <= '0;
        end else begin
            if (accept) begin
                stat_accepted <= stat_accepted + 16'd1;
            end
            if ((state == ST_GEN) && !cand_pass) begin
                stat_rejected <= stat_rejected + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_split_gen.sv
// Bench for split_gen: two instances (MAX_RETRY 15 and 9) share stimulus.
// A request-level model plans each request's outcome up front and is
// compared every cycle; directed steps add literal expectations.
module tb_split_gen;
    import split_gen_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        start, seed_load, out_ready;
    logic [17:0] seed;

    split_gen_if bus0 ();
    split_gen_if bus1 ();

    assign bus0.start = start;  assign bus0.seed_load = seed_load;
    assign bus0.seed  = seed;   assign bus0.out_ready = out_ready;
    assign bus1.start = start;  assign bus1.seed_load = seed_load;
    assign bus1.seed  = seed;   assign bus1.out_ready = out_ready;

`ifdef SPLIT_GEN_STATS_EN
    logic [15:0] acc0, rej0, acc1, rej1;
`endif

    split_gen #(.SHIFT(9), .MAX_RETRY(15), .SEED(18'h00001)) u_dut0 (
        .clk (clk), .rst_n (rst_n), .bus (bus0)
`ifdef SPLIT_GEN_STATS_EN
        , .stat_accepted (acc0), .stat_rejected (rej0)
`endif
    );

    split_gen #(.SHIFT(9), .MAX_RETRY(9), .SEED(18'h00001)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1)
`ifdef SPLIT_GEN_STATS_EN
        , .stat_accepted (acc1), .stat_rejected (rej1)
`endif
    );

    logic        o_valid[2], o_busy[2], o_fail[2];
    logic [17:0] o_data[2];
    logic [7:0]  o_retry[2];
    assign o_valid[0] = bus0.out_valid; assign o_valid[1] = bus1.out_valid;
    assign o_busy[0]  = bus0.busy;      assign o_busy[1]  = bus1.busy;
    assign o_fail[0]  = bus0.fail;      assign o_fail[1]  = bus1.fail;
    assign o_data[0]  = bus0.out_data;  assign o_data[1]  = bus1.out_data;
    assign o_retry[0] = bus0.retry_count; assign o_retry[1] = bus1.retry_count;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- request-level model ----------------
    int max_r[2] = '{15, 9};

    int          m_lfsr[2], m_t[2], m_total[2];
    bit          m_gen[2], m_pass[2];
    logic        e_valid[2], e_busy[2], e_fail[2];
    logic [17:0] e_data[2];
    logic [7:0]  e_retry[2];
    int          e_acc[2], e_rej[2];

    function automatic int lfsr_step(input int v);
        return ((v << 1) & 'h3FFFF) | (((v >> 17) ^ (v >> 10)) & 1);
    endfunction

    // SHIFT = 9: the top nine bits must not all be one.
    function automatic bit ok9(input int v);
        return ((v >> 9) & 'h1FF) != 'h1FF;
    endfunction

    // Decide how many candidates the request will test and whether it passes.
    task automatic begin_req(input int i);
        int v;
        v = m_lfsr[i];
        m_pass[i]  = 0;
        m_total[i] = max_r[i];
        for (int c = 1; c <= max_r[i]; c++) begin
            v = lfsr_step(v);
            if (ok9(v)) begin
                m_pass[i]  = 1;
                m_total[i] = c;
                break;
            end
        end
        m_gen[i]   = 1;
        m_t[i]     = 0;
        e_busy[i]  = 1;
        e_retry[i] = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_lfsr[i] = 1; m_gen[i] = 0; m_t[i] = 0;
                e_valid[i] = 0; e_busy[i] = 0; e_fail[i] = 0;
                e_data[i] = 0; e_retry[i] = 0; e_acc[i] = 0; e_rej[i] = 0;
            end else begin
                e_fail[i] = 0;
                if (m_gen[i]) begin
                    m_lfsr[i] = lfsr_step(m_lfsr[i]);
                    m_t[i]++;
                    if (m_t[i] == m_total[i] && m_pass[i]) begin
                        m_gen[i] = 0; e_valid[i] = 1; e_data[i] = 18'(m_lfsr[i]);
                    end else begin
                        e_rej[i]++;
                        e_retry[i] = 8'(m_t[i]);
                        if (m_t[i] == m_total[i]) begin
                            m_gen[i] = 0; e_fail[i] = 1; e_busy[i] = 0;
                        end
                    end
                end else if (e_valid[i]) begin
                    if (out_ready) begin
                        e_valid[i] = 0;
                        e_acc[i]++;
                        if (start) begin_req(i);
                        else e_busy[i] = 0;
                    end
                end else begin
                    if (seed_load) m_lfsr[i] = (seed == 0) ? 1 : int'(seed);
                    if (start) begin_req(i);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m_valid%0d", i), 32'(o_valid[i]), 32'(e_valid[i]));
            chk($sformatf("m_busy%0d", i),  32'(o_busy[i]),  32'(e_busy[i]));
            chk($sformatf("m_fail%0d", i),  32'(o_fail[i]),  32'(e_fail[i]));
            chk($sformatf("m_data%0d", i),  32'(o_data[i]),  32'(e_data[i]));
            chk($sformatf("m_retry%0d", i), 32'(o_retry[i]), 32'(e_retry[i]));
        end
`ifdef SPLIT_GEN_STATS_EN
        chk("m_acc0", 32'(acc0), 32'(e_acc[0] & 'hFFFF));
        chk("m_rej0", 32'(rej0), 32'(e_rej[0] & 'hFFFF));
        chk("m_acc1", 32'(acc1), 32'(e_acc[1] & 'hFFFF));
        chk("m_rej1", 32'(rej1), 32'(e_rej[1] & 'hFFFF));
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic req(input logic [17:0] s);
        seed = s; seed_load = 1'b1; start = 1'b1;
    endtask

    initial begin
        start = 0; seed_load = 0; seed = '0; out_ready = 0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", 32'(o_valid[0]), 0);
        chk("rst_data",  32'(o_data[0]),  0);
        chk("rst_busy",  32'(o_busy[0]),  0);
        chk("rst_retry", 32'(o_retry[0]), 0);
        @(negedge clk); rst_n = 1'b1;

        // Seed 1 with start: first step gives 2, no rejects.
        req(18'h00001);
        @(negedge clk); seed_load = 0; start = 0;
        chk("s1_busy",  32'(o_busy[0]),  1);
        chk("s1_valid", 32'(o_valid[0]), 0);
        @(negedge clk);
        chk("s1_valid2", 32'(o_valid[0]), 1);
        chk("s1_data",   32'(o_data[0]),  32'h00002);
        chk("s1_retry",  32'(o_retry[0]), 0);
        out_ready = 1;
        @(negedge clk); out_ready = 0;
        chk("s1_idle", 32'(o_busy[0]), 0);

        // Seed all ones: nine rejects; instance 1 fails on the ninth.
        req(18'h3FFFF);
        @(negedge clk); seed_load = 0;  // start stays high: ignored in GEN
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 1) start = 0;
            if (j == 9) begin
                chk("r9_fail1",   32'(o_fail[1]),  1);
                chk("r9_retry1",  32'(o_retry[1]), 9);
                chk("r9_busy1",   32'(o_busy[1]),  0);
                chk("r9_valid0",  32'(o_valid[0]), 0);
            end
            if (j == 10) begin
                chk("r10_valid0", 32'(o_valid[0]), 1);
                chk("r10_data0",  32'(o_data[0]),  32'h3FC00);
                chk("r10_retry0", 32'(o_retry[0]), 9);
                chk("r10_fail1",  32'(o_fail[1]),  0);
                chk("r10_valid1", 32'(o_valid[1]), 0);
            end
        end

        // Hold off the consumer; a seed_load in VALID must be ignored.
        for (int k = 0; k < 5; k++) begin
            seed_load = (k == 2); seed = 18'h00005;
            @(negedge clk);
            chk("hold_data",  32'(o_data[0]),  32'h3FC00);
            chk("hold_valid", 32'(o_valid[0]), 1);
        end
        seed_load = 0;
        out_ready = 1; start = 1;
        @(negedge clk); out_ready = 0; start = 0;
        chk("b2b_busy",  32'(o_busy[0]),  1);
        chk("b2b_valid", 32'(o_valid[0]), 0);
`ifdef SPLIT_GEN_STATS_EN
        // Two accepts so far (seed-1 request plus this one), nine rejects.
        chk("stat_acc", 32'(acc0), 2);
        chk("stat_rej", 32'(rej0), 9);
`endif
        @(negedge clk);
        chk("b2b_data",  32'(o_data[0]),  32'h3F800);
        chk("b2b_retry", 32'(o_retry[0]), 0);
        out_ready = 1;
        @(negedge clk); out_ready = 0;

        // Zero seed behaves as seed 1.
        req(18'h00000);
        @(negedge clk); seed_load = 0; start = 0;
        @(negedge clk);
        chk("z_data", 32'(o_data[0]), 32'h00002);
        out_ready = 1;
        @(negedge clk); out_ready = 0;

        // Reset in the middle of a long GEN.
        req(18'h3FFFF);
        @(negedge clk); seed_load = 0; start = 0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("mr_valid%0d", i), 32'(o_valid[i]), 0);
            chk($sformatf("mr_busy%0d", i),  32'(o_busy[i]),  0);
            chk($sformatf("mr_data%0d", i),  32'(o_data[i]),  0);
            chk($sformatf("mr_retry%0d", i), 32'(o_retry[i]), 0);
            chk($sformatf("mr_fail%0d", i),  32'(o_fail[i]),  0);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(o_valid[0]), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
